// File: rtl/key_debouncer.sv
// Per-key push-button conditioner: two-flop synchronizer, saturating stability
// filter, clean active-high levels and registered one-cycle press/release strobes.
module key_debouncer #(
  parameter int NKEYS           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_BITS        = 16,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NKEYS-1:0] keys_raw,
  output logic [NKEYS-1:0] keys,
  output logic [NKEYS-1:0] press,
  output logic [NKEYS-1:0] release_stb,
  output logic             changed
);

  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] ONE  = CNT_BITS'(1);

  logic [NKEYS-1:0]    pressed_level;
  logic [NKEYS-1:0]    s1;
  logic [NKEYS-1:0]    s2;
  logic [CNT_BITS-1:0] cnt     [NKEYS];
  logic [CNT_BITS-1:0] cnt_nxt [NKEYS];
  logic [NKEYS-1:0]    keys_nxt;
  logic [NKEYS-1:0]    press_nxt;
  logic [NKEYS-1:0]    release_nxt;

  assign pressed_level = (ACTIVE_LOW != 0) ? ~keys_raw : keys_raw;

  // Filter: any sample agreeing with the accepted level restarts the count, so
  // only an unbroken run of DEBOUNCE_CYCLES disagreeing samples flips a key.
  always_comb begin
    cnt_nxt     = cnt;
    keys_nxt    = keys;
    press_nxt   = '0;
    release_nxt = '0;
    for (int k = 0; k < NKEYS; k++) begin
      if (s2[k] == keys[k]) begin
        cnt_nxt[k] = '0;
      end else if (cnt[k] == LAST) begin
        keys_nxt[k]    = s2[k];
        cnt_nxt[k]     = '0;
        press_nxt[k]   = s2[k];
        release_nxt[k] = ~s2[k];
      end else begin
        cnt_nxt[k] = cnt[k] + ONE;
      end
    end
  end

  // Strobes are registered alongside keys so they coincide with the new level.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1          <= '0;
      s2          <= '0;
      keys        <= '0;
      press       <= '0;
      release_stb <= '0;
      changed     <= 1'b0;
      for (int k = 0; k < NKEYS; k++) cnt[k] <= '0;
    end else begin
      s1          <= pressed_level;
      s2          <= s1;
      keys        <= keys_nxt;
      press       <= press_nxt;
      release_stb <= release_nxt;
      changed     <= |(press_nxt | release_nxt);
      for (int k = 0; k < NKEYS; k++) cnt[k] <= cnt_nxt[k];
    end
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Randomized and directed stimulus for key_debouncer, checked against a
// window-based reference model through an expected-event queue.
module tb_key_debouncer;

  localparam int NK = 4;
  localparam int D  = 4;

  logic          clk;
  logic          reset;
  logic [NK-1:0] keys_raw;
  logic [NK-1:0] keys;
  logic [NK-1:0] press;
  logic [NK-1:0] release_stb;
  logic          changed;

  key_debouncer #(
    .NKEYS(NK), .DEBOUNCE_CYCLES(D), .CNT_BITS(16), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .keys_raw(keys_raw), .keys(keys),
    .press(press), .release_stb(release_stb), .changed(changed)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters and scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  bit started = 0;

  // {edge index, keys, press, release}
  logic [43:0]   exp_q[$];
  logic [NK-1:0] m_keys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, cyc);
  endtask

  // ---------------- reference model ----------------
  // A key adopts level v once the last D synchronized samples all equal v and
  // differ from its current level; the synchronizer is a two-sample delay
  // that restarts from zeros at reset.
  logic [NK-1:0] pipe_q[$];
  logic [NK-1:0] hist_q[$];
  logic [NK-1:0] m_p, m_d, m_pr, m_rl;
  bit            m_all;

  always @(posedge clk) begin
    cyc++;
    m_pr = '0;
    m_rl = '0;
    if (reset) begin
      m_keys = '0;
      pipe_q.delete();
      pipe_q.push_back('0);
      pipe_q.push_back('0);
      hist_q.delete();
      started = 1;
    end else if (started) begin
      m_p = ~keys_raw;
      m_d = pipe_q.pop_front();
      pipe_q.push_back(m_p);
      hist_q.push_back(m_d);
      if (hist_q.size() > D) void'(hist_q.pop_front());
      if (hist_q.size() == D) begin
        for (int k = 0; k < NK; k++) begin
          m_all = 1;
          foreach (hist_q[i]) if (hist_q[i][k] == m_keys[k]) m_all = 0;
          if (m_all) begin
            if (m_keys[k]) m_rl[k] = 1'b1;
            else           m_pr[k] = 1'b1;
          end
        end
      end
      m_keys = m_keys ^ (m_pr | m_rl);
      if (|(m_pr | m_rl)) exp_q.push_back({cyc[31:0], m_keys, m_pr, m_rl});
    end
  end

  // ---------------- monitor ----------------
  logic [43:0] m_e;
  always @(negedge clk) begin
    if (started) begin
      check("keys_level", 32'(keys), 32'(m_keys));
      while (exp_q.size() > 0 && exp_q[0][43:12] < cyc[31:0]) begin
        m_e = exp_q.pop_front();
        check("missed_event_edge", 32'(cyc), 32'(m_e[43:12]));
      end
      if (changed || (|press) || (|release_stb)) begin
        if (exp_q.size() == 0) begin
          check("spurious_event", {20'h0, keys, press, release_stb}, 32'h0);
        end else begin
          m_e = exp_q.pop_front();
          check("event_edge",    32'(cyc),         32'(m_e[43:12]));
          check("event_keys",    32'(keys),        32'(m_e[11:8]));
          check("event_press",   32'(press),       32'(m_e[7:4]));
          check("event_release", 32'(release_stb), 32'(m_e[3:0]));
          check("event_changed", 32'(changed),     32'd1);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [NK-1:0] v, input int n);
    keys_raw = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset    = 1'b1;
    keys_raw = 4'hF;
    repeat (3) @(negedge clk);
    check("reset_keys",    32'(keys),        32'h0);
    check("reset_press",   32'(press),       32'h0);
    check("reset_release", 32'(release_stb), 32'h0);
    check("reset_changed", 32'(changed),     32'h0);
    reset = 1'b0;
    drive(4'hF, 4);

    // clean press on key 0, held
    drive(4'b1110, 12);
    check("clean_press_level", 32'(keys), 32'h1);

    // bounce on key 1: short lows, 3-cycle highs, then held low
    drive(4'b1100, 2);
    drive(4'b1110, 3);
    drive(4'b1100, 2);
    drive(4'b1110, 3);
    drive(4'b1100, 12);
    check("bounce_level", 32'(keys), 32'h3);

    // glitch on key 2 shorter than the window
    drive(4'b1000, 3);
    drive(4'b1100, 12);
    check("glitch_level", 32'(keys), 32'h3);

    // simultaneous release, press and release of all keys
    drive(4'hF, 12);
    drive(4'h0, 12);
    check("all_pressed", 32'(keys), 32'hF);
    drive(4'hF, 12);
    check("all_released", 32'(keys), 32'h0);

    // reset mid-count on key 3, then key held through reset deassertion
    drive(4'b0111, 4);
    do_reset(2);
    drive(4'b0111, 12);
    check("held_through_reset", 32'(keys), 32'h8);
    drive(4'hF, 12);

    // randomized runs with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 3));
      drive(4'($urandom_range(0, 15)), $urandom_range(1, 8));
    end
    drive(4'hF, 12);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
